// File: rtl/i2c_slave_core.sv
// i2c_slave_core: bit-level I2C slave engine (sync, filter, START/STOP, addr, RX/TX, ACK).
// Optional general call (address byte 8'h00) enabled by defining I2C_SLAVE_GENERAL_CALL_EN.
module i2c_slave_core #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] address,
    input  logic [7:0] datasend,
    output logic       sended,
    output logic [7:0] datareceive,
    output logic       received
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_t;

    state_t state, state_n;

    logic [1:0] scl_sync, sda_sync;
    logic [FILTER_LEN-2:0] scl_hist, sda_hist;
    logic [FILTER_LEN-1:0] scl_win, sda_win;
    logic scl_f, sda_f, scl_d, sda_d;
    logic scl_rise, scl_fall, start, stop;

    logic [3:0] bitcnt, bitcnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] txsh, txsh_n;
    logic       rw, rw_n;
    logic       oe_n, rcv_n, snd_n;
    logic [7:0] drx_n;
    logic       gen_call, match, rw_in, load;

    // Filter window includes the newest synchronized sample
    assign scl_win = {scl_hist, scl_sync[1]};
    assign sda_win = {sda_hist, sda_sync[1]};

    // Synchronize pads, then accept a level only after FILTER_LEN equal samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= scl_win[FILTER_LEN-2:0];
            sda_hist <= sda_win[FILTER_LEN-2:0];
            if (&scl_win)
                scl_f <= 1'b1;
            else if (~|scl_win)
                scl_f <= 1'b0;
            if (&sda_win)
                sda_f <= 1'b1;
            else if (~|sda_win)
                sda_f <= 1'b0;
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start    = scl_f & scl_d & sda_d & ~sda_f;
    assign stop     = scl_f & scl_d & ~sda_d & sda_f;

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign gen_call = ({shift[6:0], sda_f} == 8'h00);
`else
    assign gen_call = 1'b0;
`endif

    assign match = (shift[6:0] == address) | gen_call;
    assign rw_in = sda_f & ~gen_call;
    // Reload the TX byte at the fall that ends an address ACK (read) or a master ACK
    assign load  = scl_fall & ~start & ~stop &
                   (((state == ADDR_ACK) & sda_oe & rw) |
                    ((state == TX_ACK) & (bitcnt == 4'd9)));

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state decode; START/STOP override any bit activity
    always_comb begin
        state_n = state;
        if (stop) begin
            state_n = IDLE;
        end else if (start) begin
            state_n = ADDR;
        end else begin
            unique case (state)
                ADDR:
                    if (scl_rise && bitcnt == 4'd7)
                        state_n = match ? ADDR_ACK : IGNORE;
                ADDR_ACK:
                    if (scl_fall && sda_oe)
                        state_n = rw ? TX : RX;
                RX:
                    if (scl_rise && bitcnt == 4'd7)
                        state_n = RX_ACK;
                RX_ACK:
                    if (scl_fall && sda_oe)
                        state_n = RX;
                TX:
                    if (scl_fall && bitcnt == 4'd8)
                        state_n = TX_ACK;
                TX_ACK:
                    if (scl_rise && sda_f)
                        state_n = IGNORE;
                    else if (load)
                        state_n = TX;
                default: ;
            endcase
        end
    end

    // Datapath and output decode: shifting, ACK drive, TX load, strobes
    always_comb begin
        bitcnt_n = bitcnt;
        shift_n  = shift;
        txsh_n   = txsh;
        rw_n     = rw;
        oe_n     = sda_oe;
        drx_n    = datareceive;
        rcv_n    = 1'b0;
        snd_n    = 1'b0;
        if (stop || start) begin
            oe_n     = 1'b0;
            bitcnt_n = 4'd0;
        end else begin
            unique case (state)
                ADDR:
                    if (scl_rise) begin
                        shift_n  = {shift[6:0], sda_f};
                        bitcnt_n = bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            rw_n     = rw_in;
                            bitcnt_n = 4'd0;
                        end
                    end
                ADDR_ACK, RX_ACK:
                    if (scl_fall)
                        oe_n = ~sda_oe;
                RX:
                    if (scl_rise) begin
                        shift_n  = {shift[6:0], sda_f};
                        bitcnt_n = bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            drx_n    = {shift[6:0], sda_f};
                            rcv_n    = 1'b1;
                            bitcnt_n = 4'd0;
                        end
                    end
                TX:
                    if (scl_fall) begin
                        if (bitcnt == 4'd8) begin
                            oe_n = 1'b0;
                        end else begin
                            oe_n     = ~txsh[6];
                            txsh_n   = {txsh[6:0], 1'b0};
                            bitcnt_n = bitcnt + 4'd1;
                        end
                    end
                TX_ACK:
                    if (scl_rise && !sda_f)
                        bitcnt_n = 4'd9;
                default:
                    oe_n = 1'b0;
            endcase
            if (load) begin
                txsh_n   = datasend;
                oe_n     = ~datasend[7];
                bitcnt_n = 4'd1;
                snd_n    = 1'b1;
            end
        end
    end

    // Register datapath state and outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            bitcnt      <= 4'd0;
            shift       <= 8'h00;
            txsh        <= 8'h00;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            datareceive <= 8'h00;
            received    <= 1'b0;
            sended      <= 1'b0;
        end else begin
            bitcnt      <= bitcnt_n;
            shift       <= shift_n;
            txsh        <= txsh_n;
            rw          <= rw_n;
            sda_oe      <= oe_n;
            datareceive <= drx_n;
            received    <= rcv_n;
            sended      <= snd_n;
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// tb_i2c_slave_core: directed I2C master transactions against i2c_slave_core.
// Covers write, address mismatch, read with ACK/NACK, repeated START, mid-byte reset, general call.
module tb_i2c_slave_core;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [6:0] address = 7'h28;
    logic [7:0] datasend = 8'h00;
    logic       sda_oe, sended, received;
    logic [7:0] datareceive;
    logic       sda_line;

    int errors = 0;
    int checks = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int both_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_core #(.FILTER_LEN(3)) dut (
        .clk(clk),
        .reset(reset),
        .scl_in(scl),
        .sda_in(sda_line),
        .sda_oe(sda_oe),
        .address(address),
        .datasend(datasend),
        .sended(sended),
        .datareceive(datareceive),
        .received(received)
    );

    always @(negedge clk) begin
        if (received) rx_cnt++;
        if (sended) tx_cnt++;
        if (received && sended) both_cnt++;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;
        wait_q();
        scl = 1'b1;
        wait_q();
        r = sda_line;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--)
            clock_bit(d[i], r);
        clock_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, r);
            d = {d[6:0], r};
        end
        clock_bit(nack, r);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_oe: got %b want 0", sda_oe);
        end
        checks++;
        if (received !== 1'b0) begin
            errors++;
            $display("FAIL reset_received: got %b want 0", received);
        end
        checks++;
        if (sended !== 1'b0) begin
            errors++;
            $display("FAIL reset_sended: got %b want 0", sended);
        end
        checks++;
        if (datareceive !== 8'h00) begin
            errors++;
            $display("FAIL reset_drx: got %h want 00", datareceive);
        end
        reset = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write();
        int r0, t0;
        logic ack;
        r0 = rx_cnt;
        t0 = tx_cnt;
        do_start();
        write_byte(8'h50, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr_ack: got %b want 1", ack);
        end
        write_byte(8'hA5, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_data_ack: got %b want 1", ack);
        end
        do_stop();
        wait_q();
        checks++;
        if (datareceive !== 8'hA5) begin
            errors++;
            $display("FAIL wr_drx: got %h want a5", datareceive);
        end
        checks++;
        if (rx_cnt - r0 != 1) begin
            errors++;
            $display("FAIL wr_rx_pulses: got %0d want 1", rx_cnt - r0);
        end
        checks++;
        if (tx_cnt - t0 != 0) begin
            errors++;
            $display("FAIL wr_tx_pulses: got %0d want 0", tx_cnt - t0);
        end
        checks++;
        if (sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL wr_oe_idle: got %b want 0", sda_oe);
        end
    endtask

    task automatic test_nomatch();
        int r0, t0;
        logic ack;
        r0 = rx_cnt;
        t0 = tx_cnt;
        do_start();
        write_byte(8'h52, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL nm_addr_ack: got %b want 0", ack);
        end
        write_byte(8'h11, ack);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL nm_data_ack: got %b want 0", ack);
        end
        do_stop();
        wait_q();
        checks++;
        if (rx_cnt - r0 != 0 || tx_cnt - t0 != 0) begin
            errors++;
            $display("FAIL nm_pulses: got rx=%0d tx=%0d want 0 0",
                     rx_cnt - r0, tx_cnt - t0);
        end
        checks++;
        if (datareceive !== 8'hA5) begin
            errors++;
            $display("FAIL nm_drx_hold: got %h want a5", datareceive);
        end
        checks++;
        if (sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL nm_oe: got %b want 0", sda_oe);
        end
    endtask

    task automatic test_read();
        int r0, t0;
        logic ack;
        logic [7:0] d;
        r0 = rx_cnt;
        t0 = tx_cnt;
        datasend = 8'h3C;
        do_start();
        write_byte(8'h51, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rd_addr_ack: got %b want 1", ack);
        end
        checks++;
        if (tx_cnt - t0 != 1) begin
            errors++;
            $display("FAIL rd_first_sended: got %0d want 1", tx_cnt - t0);
        end
        datasend = 8'hC3;
        read_byte(1'b0, d);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL rd_byte1: got %h want 3c", d);
        end
        read_byte(1'b1, d);
        checks++;
        if (d !== 8'hC3) begin
            errors++;
            $display("FAIL rd_byte2: got %h want c3", d);
        end
        do_stop();
        wait_q();
        checks++;
        if (tx_cnt - t0 != 2) begin
            errors++;
            $display("FAIL rd_tx_pulses: got %0d want 2", tx_cnt - t0);
        end
        checks++;
        if (rx_cnt - r0 != 0) begin
            errors++;
            $display("FAIL rd_rx_pulses: got %0d want 0", rx_cnt - r0);
        end
        checks++;
        if (sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL rd_oe_idle: got %b want 0", sda_oe);
        end
    endtask

    task automatic test_back_to_back();
        int r0, t0;
        logic ack;
        logic [7:0] d;
        r0 = rx_cnt;
        t0 = tx_cnt;
        datasend = 8'h96;
        do_start();
        write_byte(8'h50, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rs_addr_ack: got %b want 1", ack);
        end
        write_byte(8'h01, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rs_data_ack: got %b want 1", ack);
        end
        do_start();
        write_byte(8'h51, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rs_raddr_ack: got %b want 1", ack);
        end
        checks++;
        if (datareceive !== 8'h01) begin
            errors++;
            $display("FAIL rs_drx: got %h want 01", datareceive);
        end
        checks++;
        if (rx_cnt - r0 != 1) begin
            errors++;
            $display("FAIL rs_rx_pulses: got %0d want 1", rx_cnt - r0);
        end
        read_byte(1'b1, d);
        checks++;
        if (d !== 8'h96) begin
            errors++;
            $display("FAIL rs_tx_byte: got %h want 96", d);
        end
        do_stop();
        wait_q();
        checks++;
        if (tx_cnt - t0 != 1) begin
            errors++;
            $display("FAIL rs_tx_pulses: got %0d want 1", tx_cnt - t0);
        end
    endtask

    task automatic test_reset_mid();
        logic ack, r;
        logic [7:0] v;
        v = 8'h5A;
        do_start();
        write_byte(8'h50, ack);
        for (int i = 7; i >= 0; i--)
            clock_bit(v[i], r);
        checks++;
        if (sda_oe !== 1'b1) begin
            errors++;
            $display("FAIL rm_ack_drive: got %b want 1", sda_oe);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL rm_oe: got %b want 0", sda_oe);
        end
        checks++;
        if (datareceive !== 8'h00) begin
            errors++;
            $display("FAIL rm_drx: got %h want 00", datareceive);
        end
        checks++;
        if (received !== 1'b0 || sended !== 1'b0) begin
            errors++;
            $display("FAIL rm_strobes: got %b%b want 00", received, sended);
        end
        sda_m = 1'b1;
        repeat (2) @(negedge clk);
        scl = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_general_call();
        logic ack;
        do_start();
        write_byte(8'h00, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL gc_addr_ack: got %b want 1", ack);
        end
        write_byte(8'h7E, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL gc_data_ack: got %b want 1", ack);
        end
        do_stop();
        wait_q();
        checks++;
        if (datareceive !== 8'h7E) begin
            errors++;
            $display("FAIL gc_drx: got %h want 7e", datareceive);
        end
`else
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL gc_nack: got %b want 0", ack);
        end
        do_stop();
        wait_q();
        checks++;
        if (sda_oe !== 1'b0) begin
            errors++;
            $display("FAIL gc_oe: got %b want 0", sda_oe);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_nomatch();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_general_call();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d want 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_core.md
# i2c_slave_core

Bit-level I2C slave protocol engine sitting directly below the slave application driver. Samples the open-drain SCL/SDA bus, detects START/STOP, matches the 7-bit device address supplied by the driver, shifts bytes in and out, and drives ACK. Hands received bytes upward with a `received` strobe and requests transmit bytes with a `sended` strobe.

## Interface
- `FILTER_LEN`, 3: consecutive identical samples required before a synchronized SCL/SDA level is accepted.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `scl_in`  in  1  raw SCL from pad.
- `sda_in`  in  1  raw SDA from pad.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `address`  in  7  device address; sampled at the 8th SCL rise of the address byte.
- `datasend`  in  8  next byte to transmit; latched on the `sended` cycle.
- `sended`  out  1  one-cycle pulse: `datasend` loaded into the TX shifter.
- `datareceive`  out  8  last received data byte; holds until the next byte.
- `received`  out  1  one-cycle pulse: `datareceive` updated.

## Operation
- Input path: 2-flop synchronizer per line, then glitch filter (`FILTER_LEN` equal samples). Edge detection uses the filtered values.
- START: filtered SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are accepted in every state.
- START, including repeated START → ADDR, bit counter 0. STOP → IDLE, `sda_oe`=0.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
- Sampling: SDA is sampled on the filtered SCL rise, MSB first, bit counter 0..7. `sda_oe` changes only on the filtered SCL fall.
- ADDR: at the 8th rise compare shift[7:1] with `address`.
  - Mismatch → IGNORE. `sda_oe` stays 0 until START/STOP.
  - Match → ADDR_ACK: `sda_oe`=1 from the next SCL fall to the following fall.
  - Leaving ADDR_ACK, shift[0]=0 → RX; shift[0]=1 → TX.
- RX: at the 8th rise, `datareceive` ← shift and `received` pulses in the same cycle. Then RX_ACK: `sda_oe`=1 for the 9th bit, then back to RX.
- TX load: at the fall ending ADDR_ACK or TX_ACK(ACK), latch `datasend`, pulse `sended`, and drive bit7 (`sda_oe` = ~bit).
- TX shifting: subsequent falls drive bits 6..0. At the fall after bit 0, release SDA and go to TX_ACK.
- TX_ACK: sample SDA at the 9th rise.
  - 0 (master ACK) → reload, TX.
  - 1 (NACK) → IGNORE.
- Reset (any state, mid-byte included): next edge gives IDLE, `sda_oe`=0, `received`=0, `sended`=0, `datareceive`=8'h00, counters 0.

## Timing
- Input latency: 2 + `FILTER_LEN` clk cycles from pad to filtered level.
- `clk` must be ≥ 20× SCL frequency. `FILTER_LEN` × clk period must be < SCL high/low time.
- `received` and `sended` are exactly 1 clk wide and never asserted simultaneously. Consumers sampling on either clk edge see the strobe.
- `datasend` must be stable by the `sended` cycle. The consumer refreshes it for the next byte within 8 SCL periods.
- START/STOP detected in the same cycle as an SCL edge: START/STOP wins and the bit is discarded.
- No clock stretching: bus timing is owned by the master.

## Configuration
- `I2C_SLAVE_GENERAL_CALL_EN` defined: address byte 8'h00 is also a match. The core ACKs and enters RX; the R/W bit is forced to write.
- Not defined: 8'h00 matches only if `address`==7'h00 and R/W=0, i.e. the normal compare.

## Test plan
- `address`=7'h28. Master sends START, 8'h50, 8'hA5, STOP → ACK on both bytes; `datareceive`=8'hA5; one `received` pulse; ends in IDLE.
- Master sends START, 8'h52 → no ACK (`sda_oe` stays 0); no strobes; 8'h11 following is ignored until STOP.
- Master sends START, 8'h51; `datasend`=8'h3C → `sended` pulse; SDA carries 0x3C. Master ACKs; `datasend`=8'hC3 → second `sended`; SDA carries 0xC3. Master NACKs, then STOP → `sda_oe`=0, IDLE.
- Master sends START, 8'h50, 8'h01, repeated START, 8'h51 → `received` shows 8'h01, then the transfer switches to TX with one `sended` pulse.
- `reset`=0 asserted during RX_ACK while `sda_oe`=1 → on the next clk, `sda_oe`=0 and all outputs hold their reset values.
- With the macro: master sends START, 8'h00, 8'h7E → ACK on both; `datareceive`=8'h7E. Without the macro and `address`=7'h28 → NACK.
